// File: rtl/tree_output_packer.sv
// tree_output_packer
//   Drain end of the merge sorter tree. Collects the tree's sorted record
//   stream into words of 2^P_LOG records and queues them in a small
//   first-word-fall-through FIFO for the memory writer. It back-pressures
//   the tree through a registered STALL. It also flags key-order
//   violations and dropped records in a sticky error register.
//
// Ports
//   CLK      clock
//   RST_X    synchronous reset, active-low
//   DIN      sorted record from the tree; the key is DIN[KEYW-1:0]
//   DINEN    DIN valid
//   FLUSH    end-of-sequence pulse; pads and emits any partial word
//   STALL    registered stall request to the tree
//   DOT      packed word; lane 0 holds the earliest record
//   DOTEN    DOT valid (FIFO non-empty)
//   DOT_RDY  downstream accepts DOT
//   CNT      records accepted since reset, wraps modulo 2^32
//   ERR      sticky errors; bit0 order violation, bit1 overflow

module tree_output_packer #(
  parameter int P_LOG    = 3,
  parameter int FIFO_LOG = 2,
  parameter int DATW     = 64,
  parameter int KEYW     = 32,
  parameter int TREE_LAT = 4
) (
  input  logic                       CLK,
  input  logic                       RST_X,
  input  logic [DATW-1:0]            DIN,
  input  logic                       DINEN,
  input  logic                       FLUSH,
  output logic                       STALL,
  output logic [(DATW<<P_LOG)-1:0]   DOT,
  output logic                       DOTEN,
  input  logic                       DOT_RDY,
  output logic [31:0]                CNT,
  output logic [1:0]                 ERR
);

  localparam int NLANES = 1 << P_LOG;
  localparam int FDEPTH = 1 << FIFO_LOG;
  localparam int WORDW  = DATW * NLANES;
  localparam int CW     = FIFO_LOG + 1;

  typedef enum logic {ST_RUN, ST_FLUSH_WAIT} state_t;

  state_t               state;
  logic [P_LOG-1:0]     idx;
  logic [DATW-1:0]      lane_q   [NLANES];
  logic [WORDW-1:0]     fifo_mem [FDEPTH];
  logic [FIFO_LOG-1:0]  rd_ptr;
  logic [FIFO_LOG-1:0]  wr_ptr;
  logic [CW-1:0]        count;
  logic [KEYW-1:0]      last_key;
  logic                 check_en;

  logic                 pop;
  logic                 push;
  logic                 accept;
  logic                 drop;
  logic                 go_pending;
  logic                 leave_pending;
  logic                 pend_next;
  logic [P_LOG-1:0]     wr_lane;
  logic [P_LOG-1:0]     placed;
  logic [P_LOG-1:0]     idx_next;
  logic [CW-1:0]        count_next;
  logic [WORDW-1:0]     push_word;
  int                   pad_lim;
  int                   free_cur;
  int                   free_next;

  assign DOTEN = (count != '0);
  assign DOT   = fifo_mem[rd_ptr];

  // Record slots are counted as whole FIFO words that are still free,
  // minus the lanes already claimed by the partial word. A record is only
  // taken when that count is positive, so a partial word always has a
  // FIFO word reserved for it. The one exception is a padded word held
  // back by a flush.
  // While a padded word is held back, the FIFO is full. The held word
  // goes out on the first pop. A record arriving in that same cycle starts
  // the next word in lane 0.
  always_comb begin
    pop           = DOTEN && DOT_RDY;
    push          = 1'b0;
    accept        = 1'b0;
    drop          = 1'b0;
    go_pending    = 1'b0;
    leave_pending = 1'b0;
    wr_lane       = idx;
    placed        = idx;
    idx_next      = idx;
    pad_lim       = NLANES;
    free_cur      = (FDEPTH - int'(count) + int'(pop)) * NLANES - int'(idx);

    if (state == ST_FLUSH_WAIT) begin
      pad_lim = int'(idx);
      if (pop) begin
        push          = 1'b1;
        leave_pending = 1'b1;
        wr_lane       = '0;
        idx_next      = '0;
        if (DINEN) begin
          accept   = 1'b1;
          idx_next = P_LOG'(1);
        end
      end else begin
        drop = DINEN;
      end
    end else begin
      accept   = DINEN && (free_cur > 0);
      drop     = DINEN && !accept;
      placed   = idx + P_LOG'(accept);
      idx_next = placed;
      if (accept && (idx == {P_LOG{1'b1}})) begin
        push = 1'b1;
      end else if (FLUSH && (placed != '0)) begin
        pad_lim = int'(placed);
        if ((count != CW'(FDEPTH)) || pop) begin
          push     = 1'b1;
          idx_next = '0;
        end else begin
          go_pending = 1'b1;
        end
      end
    end

    // Build the outgoing word. A record accepted this cycle into the
    // current word is merged in, and lanes past the fill point read as
    // all-ones padding.
    push_word = '1;
    for (int k = 0; k < NLANES; k++) begin
      if (k < pad_lim) begin
        if ((state == ST_RUN) && accept && (idx == P_LOG'(k)))
          push_word[k*DATW +: DATW] = DIN;
        else
          push_word[k*DATW +: DATW] = lane_q[k];
      end
    end

    count_next = count + CW'(push) - CW'(pop);
    free_next  = (FDEPTH - int'(count_next)) * NLANES - int'(idx_next);
    pend_next  = go_pending || ((state == ST_FLUSH_WAIT) && !leave_pending);
  end

  // Lane and FIFO storage carries no reset. Anything stale is either
  // overwritten before use or masked by padding and empty pointers.
  always_ff @(posedge CLK) begin
    if (accept)
      lane_q[wr_lane] <= DIN;
    if (push)
      fifo_mem[wr_ptr] <= push_word;
  end

  // Control state, counters and sticky flags.
  // FLUSH is applied after the record placement, so a record that arrives
  // with FLUSH is still order-checked before the checker re-arms.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state    <= ST_RUN;
      idx      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      STALL    <= 1'b0;
      CNT      <= '0;
      ERR      <= '0;
      last_key <= '0;
      check_en <= 1'b0;
    end else begin
      idx   <= idx_next;
      count <= count_next;
      if (push)
        wr_ptr <= wr_ptr + FIFO_LOG'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_LOG'(1);
      if (accept) begin
        CNT      <= CNT + 32'd1;
        last_key <= DIN[KEYW-1:0];
        check_en <= 1'b1;
        if (check_en && (DIN[KEYW-1:0] < last_key))
          ERR[0] <= 1'b1;
      end
      if (FLUSH)
        check_en <= 1'b0;
      if (drop)
        ERR[1] <= 1'b1;
      if (go_pending)
        state <= ST_FLUSH_WAIT;
      else if (leave_pending)
        state <= ST_RUN;
      STALL <= (free_next <= TREE_LAT) || pend_next;
    end
  end

endmodule

// File: tb/tb_tree_output_packer.sv
// tb_tree_output_packer
//   Self-checking bench for tree_output_packer. A queue-based reference
//   model tracks the partial word, FIFO occupancy, counters and error
//   flags. Expected packed words go into a scoreboard queue, and a
//   separate monitor checks them whenever the DUT hands a word downstream.

module tb_tree_output_packer;

  localparam int P_LOG    = 3;
  localparam int FIFO_LOG = 2;
  localparam int DATW     = 64;
  localparam int KEYW     = 32;
  localparam int TREE_LAT = 4;
  localparam int N        = 1 << P_LOG;
  localparam int DEPTH    = 1 << FIFO_LOG;
  localparam int WORDW    = DATW * N;

  typedef logic [WORDW-1:0] word_t;

  logic              CLK = 1'b0;
  logic              RST_X = 1'b0;
  logic [DATW-1:0]   DIN = '0;
  logic              DINEN = 1'b0;
  logic              FLUSH = 1'b0;
  logic              DOT_RDY = 1'b0;
  logic              STALL;
  logic [WORDW-1:0]  DOT;
  logic              DOTEN;
  logic [31:0]       CNT;
  logic [1:0]        ERR;

  tree_output_packer #(
    .P_LOG(P_LOG), .FIFO_LOG(FIFO_LOG), .DATW(DATW), .KEYW(KEYW), .TREE_LAT(TREE_LAT)
  ) dut (
    .CLK(CLK), .RST_X(RST_X), .DIN(DIN), .DINEN(DINEN), .FLUSH(FLUSH),
    .STALL(STALL), .DOT(DOT), .DOTEN(DOTEN), .DOT_RDY(DOT_RDY),
    .CNT(CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model state
  word_t            exp_q[$];
  logic [DATW-1:0]  part[$];
  int               mdl_occ;
  bit               pending;
  logic [31:0]      exp_cnt;
  logic [1:0]       exp_err;
  logic [KEYW-1:0]  last_key;
  bit               armed;
  bit               exp_stall;
  word_t            mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Words leave the DUT on any edge where DOTEN && DOT_RDY hold.
  always @(negedge CLK) begin
    if (RST_X && DOTEN && DOT_RDY) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL word_unexpected: got %0h expected no word", DOT);
      end else begin
        mon_exp = exp_q.pop_front();
        if (DOT !== mon_exp) begin
          bad++;
          $display("[TB] FAIL word_data: got %0h expected %0h", DOT, mon_exp);
        end
      end
    end
  end

  function automatic word_t packWord();
    word_t w;
    w = '1;
    for (int k = 0; k < part.size(); k++)
      w[k*DATW +: DATW] = part[k];
    return w;
  endfunction

  task automatic pushWord();
    exp_q.push_back(packWord());
    mdl_occ++;
    part.delete();
  endtask

  task automatic acceptRecord(input logic [DATW-1:0] d);
    part.push_back(d);
    exp_cnt++;
    if (armed && (d[KEYW-1:0] < last_key))
      exp_err[0] = 1'b1;
    last_key = d[KEYW-1:0];
    armed = 1'b1;
    if (part.size() == N)
      pushWord();
  endtask

  task automatic modelStep(input logic [DATW-1:0] d, input bit en, input bit fl, input bit rdy);
    bit pop;
    int cap;
    pop = (mdl_occ > 0) && rdy;
    if (pending) begin
      if (pop) begin
        mdl_occ--;
        pushWord();
        pending = 1'b0;
        if (en) acceptRecord(d);
      end else if (en) begin
        exp_err[1] = 1'b1;
      end
    end else begin
      cap = (DEPTH - mdl_occ + int'(pop)) * N - part.size();
      if (pop) mdl_occ--;
      if (en) begin
        if (cap > 0) acceptRecord(d);
        else exp_err[1] = 1'b1;
      end
      if (fl && (part.size() != 0)) begin
        if (mdl_occ < DEPTH) pushWord();
        else pending = 1'b1;
      end
    end
    if (fl) armed = 1'b0;
    exp_stall = (((DEPTH - mdl_occ) * N - part.size()) <= TREE_LAT) || pending;
  endtask

  task automatic checkOutput();
    check("cnt", 64'(CNT), 64'(exp_cnt));
    check("err", 64'(ERR), 64'(exp_err));
    check("stall", 64'(STALL), 64'(exp_stall));
    check("doten", 64'(DOTEN), 64'(mdl_occ > 0));
  endtask

  task automatic applyStimulus(input logic [DATW-1:0] d, input bit en, input bit fl, input bit rdy);
    checkOutput();
    DIN = d;
    DINEN = en;
    FLUSH = fl;
    DOT_RDY = rdy;
    modelStep(d, en, fl, rdy);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      applyStimulus('0, 1'b0, 1'b0, rdy);
  endtask

  task automatic doReset();
    DINEN = 1'b0;
    FLUSH = 1'b0;
    DOT_RDY = 1'b0;
    RST_X = 1'b0;
    @(posedge CLK);
    #1;
    RST_X = 1'b1;
    exp_q.delete();
    part.delete();
    mdl_occ = 0;
    pending = 1'b0;
    exp_cnt = '0;
    exp_err = '0;
    last_key = '0;
    armed = 1'b0;
    exp_stall = 1'b0;
    checkOutput();
  endtask

  function automatic logic [DATW-1:0] rec(input int unsigned key);
    return {32'($urandom), 32'(key)};
  endfunction

  int unsigned rkey;

  initial begin
    #1;
    // plain word of eight ascending keys
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(rec(i), 1'b1, 1'b0, 1'b1);
    check("cnt_eight", 64'(CNT), 64'd8);
    idle(4, 1'b1);

    // fill the FIFO with no drain, watch STALL and overflow
    doReset();
    for (int i = 1; i <= 33; i++) begin
      applyStimulus(rec(i), 1'b1, 1'b0, 1'b0);
      if (i == 27) check("stall_before_lat", 64'(STALL), 64'd0);
      if (i == 28) check("stall_at_lat", 64'(STALL), 64'd1);
    end
    check("ovf_flag", 64'(ERR[1]), 64'd1);
    check("ovf_cnt", 64'(CNT), 64'd32);
    idle(8, 1'b1);
    check("stall_released", 64'(STALL), 64'd0);

    // partial word flushed with padding, then a clean word
    doReset();
    for (int i = 10; i <= 12; i++) applyStimulus(rec(i), 1'b1, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    for (int i = 13; i <= 20; i++) applyStimulus(rec(i), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // order violation is sticky, FLUSH re-arms the checker
    doReset();
    applyStimulus(rec(5), 1'b1, 1'b0, 1'b1);
    applyStimulus(rec(3), 1'b1, 1'b0, 1'b1);
    check("order_err", 64'(ERR[0]), 64'd1);
    applyStimulus('0, 1'b0, 1'b1, 1'b1);
    applyStimulus(rec(1), 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    check("order_err_sticky", 64'(ERR[0]), 64'd1);
    doReset();
    check("err_cleared", 64'(ERR), 64'd0);

    // FLUSH on a completing record, then FLUSH that fills the FIFO
    for (int i = 1; i <= 7; i++) applyStimulus(rec(i), 1'b1, 1'b0, 1'b1);
    applyStimulus(rec(8), 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    doReset();
    for (int i = 1; i <= 26; i++) applyStimulus(rec(i), 1'b1, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    check("stall_full", 64'(STALL), 64'd1);
    idle(6, 1'b1);

    // reset with a partial word and queued words
    doReset();
    for (int i = 1; i <= 21; i++) applyStimulus(rec(i), 1'b1, 1'b0, 1'b0);
    doReset();
    check("reset_doten", 64'(DOTEN), 64'd0);
    for (int i = 1; i <= 8; i++) applyStimulus(rec(i), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // randomized traffic
    doReset();
    rkey = 100;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset();
      end else begin
        if ($urandom_range(0, 29) == 0) rkey = rkey - $urandom_range(1, 5);
        else rkey = rkey + $urandom_range(0, 3);
        applyStimulus(rec(rkey), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 1) == 1));
      end
    end
    idle(12, 1'b1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
